// File: rtl/transaction_chain_display.sv
// Pixel sequencer for the transaction chain graphic: a row of alternating
// connector bars and node boxes, emitted one pixel per clock with clipping.
module transaction_chain_display #(
    parameter int unsigned X_W        = 9,
    parameter int unsigned Y_W        = 8,
    parameter int unsigned X_MAX      = 320,
    parameter int unsigned Y_MAX      = 240,
    parameter int unsigned NUM_NODES  = 3,
    parameter int unsigned CONN_W     = 16,
    parameter int unsigned CONN_H     = 2,
    parameter int unsigned NODE_W     = 32,
    parameter int unsigned NODE_H     = 16,
    parameter int unsigned NODE_Y_OFS = 8,
    parameter int unsigned COLOR_W    = 3,
    parameter logic [COLOR_W-1:0] ACTIVE_COLOR = 3'b010,
    parameter logic [COLOR_W-1:0] IDLE_COLOR   = 3'b111,
    localparam int unsigned STAGES = 2 * NUM_NODES + 1,
    localparam int unsigned PROG_W = $clog2(STAGES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     start_x,
    input  logic [Y_W-1:0]     start_y,
    input  logic [PROG_W-1:0]  progress,
    output logic [X_W-1:0]     x_coord,
    output logic [Y_W-1:0]     y_coord,
    output logic [COLOR_W-1:0] colour,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam int unsigned MAX_W = (CONN_W > NODE_W) ? CONN_W : NODE_W;
    localparam int unsigned MAX_H = (CONN_H > NODE_H) ? CONN_H : NODE_H;
    localparam int unsigned OX_W  = $clog2(MAX_W + 1);
    localparam int unsigned OY_W  = $clog2(MAX_H + 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t              state_q, state_d;
    logic [PROG_W-1:0]   stage_q, stage_d;
    logic [PROG_W-1:0]   prog_q, prog_d;
    logic [OX_W-1:0]     ox_q, ox_d;
    logic [OY_W-1:0]     oy_q, oy_d;
    logic [X_W-1:0]      stage_x_q, stage_x_d;
    logic [Y_W-1:0]      base_y_q, base_y_d;

    logic [X_W-1:0]      x_d;
    logic [Y_W-1:0]      y_d;
    logic [COLOR_W-1:0]  colour_d;
    logic                plot_d, busy_d, done_d;

    logic                is_node, last_x, last_y, last_stage, visible;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;

    // Current pixel position: odd stages are nodes, raised above the connector row.
    always_comb begin
        is_node    = stage_q[0];
        last_x     = is_node ? (ox_q == OX_W'(NODE_W - 1)) : (ox_q == OX_W'(CONN_W - 1));
        last_y     = is_node ? (oy_q == OY_W'(NODE_H - 1)) : (oy_q == OY_W'(CONN_H - 1));
        last_stage = (stage_q == PROG_W'(STAGES - 1));
        pix_x      = stage_x_q + X_W'(ox_q);
        pix_y      = (is_node ? (base_y_q - Y_W'(NODE_Y_OFS)) : base_y_q) + Y_W'(oy_q);
        visible    = (32'(pix_x) < X_MAX) && (32'(pix_y) < Y_MAX);
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        prog_d    = prog_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        stage_x_d = stage_x_q;
        base_y_d  = base_y_q;
        x_d       = x_coord;
        y_d       = y_coord;
        colour_d  = colour;
        plot_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    prog_d    = progress;
                    stage_x_d = start_x;
                    base_y_d  = start_y;
                    stage_d   = '0;
                    ox_d      = '0;
                    oy_d      = '0;
                    state_d   = DRAW;
                end
            end
            DRAW: begin
                x_d      = pix_x;
                y_d      = pix_y;
                colour_d = (stage_q < prog_q) ? ACTIVE_COLOR : IDLE_COLOR;
                plot_d   = visible;
                busy_d   = 1'b1;
                if (!last_x) begin
                    ox_d = ox_q + OX_W'(1);
                end else begin
                    ox_d = '0;
                    if (!last_y) begin
                        oy_d = oy_q + OY_W'(1);
                    end else begin
                        // Stage boundary: next origin is this origin plus this stage's width.
                        oy_d      = '0;
                        stage_d   = stage_q + PROG_W'(1);
                        stage_x_d = stage_x_q + (is_node ? X_W'(NODE_W) : X_W'(CONN_W));
                        if (last_stage) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            prog_q    <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            stage_x_q <= '0;
            base_y_q  <= '0;
            x_coord   <= '0;
            y_coord   <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            prog_q    <= prog_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            stage_x_q <= stage_x_d;
            base_y_q  <= base_y_d;
            x_coord   <= x_d;
            y_coord   <= y_d;
            colour    <= colour_d;
            plot      <= plot_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_transaction_chain_display.sv
// Bench for transaction_chain_display: default-size and small-size instances
// compared cycle by cycle against a geometric pixel-list model.
module tb_transaction_chain_display;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       b_start, s_start;
    logic [8:0] b_sx, s_sx;
    logic [7:0] b_sy, s_sy;
    logic [2:0] b_prog;
    logic [1:0] s_prog;
    logic [8:0] b_x, s_x;
    logic [7:0] b_y, s_y;
    logic [2:0] b_col, s_col;
    logic       b_plot, s_plot, b_busy, s_busy, b_done, s_done;

    transaction_chain_display dut_big (
        .clk(clk), .reset(reset), .start(b_start), .start_x(b_sx), .start_y(b_sy),
        .progress(b_prog), .x_coord(b_x), .y_coord(b_y), .colour(b_col),
        .plot(b_plot), .busy(b_busy), .done(b_done)
    );

    transaction_chain_display #(
        .NUM_NODES(1), .NODE_W(8), .NODE_H(4), .CONN_W(4), .CONN_H(1)
    ) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .start_x(s_sx), .start_y(s_sy),
        .progress(s_prog), .x_coord(s_x), .y_coord(s_y), .colour(s_col),
        .plot(s_plot), .busy(s_busy), .done(s_done)
    );

    bit sel;
    int total = 0;
    int bad = 0;
    int exp_q[$];
    int obs_q[$];
    int plots;
    int done_at;
    int done_cnt;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observable word: done[22] busy[21] plot[20] colour[19:17] y[16:9] x[8:0]
    function automatic int pack(input int dn, input int bz, input int p, input int c,
                                input int y, input int x);
        return ((dn & 1) << 22) | ((bz & 1) << 21) | ((p & 1) << 20) |
               ((c & 7) << 17) | ((y & 255) << 9) | (x & 511);
    endfunction

    function automatic int cur_word();
        if (sel) return pack(int'(s_done), int'(s_busy), int'(s_plot), int'(s_col), int'(s_y), int'(s_x));
        return pack(int'(b_done), int'(b_busy), int'(b_plot), int'(b_col), int'(b_y), int'(b_x));
    endfunction

    task automatic set_start(input bit v, input int sx, input int sy, input int prog);
        if (sel) begin
            s_start = v; s_sx = 9'(sx); s_sy = 8'(sy); s_prog = 2'(prog);
        end else begin
            b_start = v; b_sx = 9'(sx); b_sy = 8'(sy); b_prog = 3'(prog);
        end
    endtask

    // Expected pixel list straight from the chain geometry, 9/8-bit wrap, 320x240 clip.
    task automatic build_exp(input int nn, input int cw, input int ch, input int nw,
                             input int nh, input int ofs, input int sx, input int sy,
                             input int prog);
        int ox0, oy0, w, h, px, py;
        exp_q.delete();
        for (int s = 0; s < 2 * nn + 1; s++) begin
            if (s % 2 == 0) begin
                ox0 = sx + (s / 2) * (cw + nw); oy0 = sy; w = cw; h = ch;
            end else begin
                ox0 = sx + cw + (s / 2) * (cw + nw); oy0 = sy - ofs; w = nw; h = nh;
            end
            for (int yy = 0; yy < h; yy++) begin
                for (int xx = 0; xx < w; xx++) begin
                    px = (ox0 + xx) & 511;
                    py = (oy0 + yy) & 255;
                    exp_q.push_back(pack(0, 1, (px < 320 && py < 240) ? 1 : 0,
                                         (s < prog) ? 2 : 7, py, px));
                end
            end
        end
    endtask

    // inj_kind: 0 none, 1 start pulse at draw cycle inj_at, 2 reset at draw cycle inj_at
    task automatic run_draw(input string tag, input int sx, input int sy, input int prog,
                            input int inj_at, input int inj_kind);
        int n, exp_plots, w;
        if (sel) build_exp(1, 4, 1, 8, 4, 8, sx, sy, prog);
        else     build_exp(3, 16, 2, 32, 16, 8, sx, sy, prog);
        n = exp_q.size();
        exp_plots = 0;
        foreach (exp_q[i]) if (((exp_q[i] >> 20) & 1) == 1) exp_plots++;
        obs_q.delete();
        plots = 0; done_at = -1; done_cnt = 0;

        @(negedge clk); set_start(1'b1, sx, sy, prog);
        @(negedge clk); set_start(1'b0, sx, sy, prog);
        check($sformatf("%s_idle_flags", tag), (cur_word() >> 20) & 7, 0);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            set_start(1'b0, sx, sy, prog);
            w = cur_word();
            if (((w >> 20) & 1) == 1) plots++;
            if (((w >> 22) & 1) == 1) begin done_at = k; done_cnt++; end
            if (k <= n) begin
                obs_q.push_back(w);
                check($sformatf("%s_pix%0d", tag, k - 1), w, exp_q[k - 1]);
            end else if (k == n + 1) begin
                check($sformatf("%s_done", tag), w, (exp_q[n - 1] & 32'hFFFFF & ~(1 << 20)) | (1 << 22));
            end else begin
                check($sformatf("%s_after", tag), w, exp_q[n - 1] & 32'hFFFFF & ~(1 << 20));
            end
            if (k == inj_at && inj_kind == 1) set_start(1'b1, 200, 17, 0);
            if (k == inj_at && inj_kind == 2) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check($sformatf("%s_abort_outputs", tag), cur_word(), 0);
                for (int j = 0; j < 40; j++) begin
                    @(negedge clk);
                    if (((cur_word() >> 22) & 1) == 1) done_cnt++;
                    if (((cur_word() >> 21) & 1) == 1) done_cnt++;
                end
                check($sformatf("%s_abort_quiet", tag), done_cnt, 0);
                return;
            end
        end
        check($sformatf("%s_plots", tag), plots, exp_plots);
        check($sformatf("%s_done_cycle", tag), done_at, n + 1);
        check($sformatf("%s_done_count", tag), done_cnt, 1);
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        b_start = 1'b0; b_sx = '0; b_sy = '0; b_prog = '0;
        s_start = 1'b0; s_sx = '0; s_sy = '0; s_prog = '0;
        repeat (3) @(negedge clk);
        check("reset_big", cur_word(), 0);
        sel = 1'b1;
        check("reset_small", cur_word(), 0);
        sel = 1'b0;
        reset = 1'b0;

        run_draw("first", 40, 100, 0, 0, 0);
        check("first_pixel", obs_q[0], pack(0, 1, 1, 7, 100, 40));

        run_draw("full", 0, 100, 3, 0, 0);
        check("full_plots_1664", plots, 1664);
        check("full_done_1665", done_at, 1665);
        check("full_pix32", obs_q[32], pack(0, 1, 1, 2, 92, 16));
        check("full_pix543", obs_q[543] & 32'h1FFFF, pack(0, 0, 0, 0, 107, 47));
        check("full_pix544", obs_q[544], pack(0, 1, 1, 2, 100, 48));
        check("full_stage3_colour", (obs_q[576] >> 17) & 7, 7);

        run_draw("clip", 0, 4, 3, 0, 0);
        check("clip_plots_1280", plots, 1280);
        check("clip_cycles", obs_q.size(), 1664);
        check("clip_row252", (obs_q[32] >> 20) & 1, 0);

        run_draw("ign_start", 0, 100, 3, 500, 1);
        check("ign_done_1665", done_at, 1665);

        run_draw("abort", 0, 100, 3, 700, 2);
        run_draw("restart", 0, 100, 3, 0, 0);
        check("restart_pix0", obs_q[0], pack(0, 1, 1, 2, 100, 0));

        for (int r = 0; r < 3; r++) begin
            run_draw($sformatf("rnd%0d", r), int'($urandom_range(511)), int'($urandom_range(255)),
                     int'($urandom_range(7)), 0, 0);
        end

        sel = 1'b1;
        run_draw("small", 10, 50, 7, 0, 0);
        check("small_done_41", done_at, 41);
        foreach (obs_q[i]) check($sformatf("small_active%0d", i), (obs_q[i] >> 17) & 7, 2);
        for (int r = 0; r < 2; r++) begin
            run_draw($sformatf("srnd%0d", r), int'($urandom_range(511)), int'($urandom_range(255)),
                     int'($urandom_range(3)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
